// File: rtl/dmem.sv
// dmem: word-addressed data memory with combinational read, synchronous
// write and a synchronous clear-all reset. Byte address in, 32-bit word out.
module dmem #(
  parameter int unsigned DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_idx;
  logic          w_unused_addr;

  // Word index; byte-offset bits and bits above the index field are dropped,
  // so addresses alias modulo DEPTH*4.
  assign w_idx         = addr[AW+1:2];
  assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};

  // Combinational read port, no bypass of a write pending on this cycle.
  assign rd = r_mem[w_idx];

  // Clear every word on reset (reset wins over write); otherwise write one word.
  // An X on we fails the if-test in simulation, so memory is left intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= 32'h0000_0000;
      end
    end else if (we == 1'b1) begin
      r_mem[w_idx] <= wd;
    end
  end

endmodule

// File: tb/tb_dmem.sv
// tb_dmem: directed self-checking bench for dmem (DEPTH = 128).
module tb_dmem;

  localparam int unsigned DEPTH = 128;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;

  int errors = 0;
  int checks = 0;

  dmem #(.DEPTH(DEPTH)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .wd   (wd),
    .rd   (rd)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = 32'h0;
    wd   = 32'h0;

    // Reset clear: two reset edges, then sweep every word.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      addr = 32'(i * 4);
      #1;
      check("reset_clear", rd, 32'h0);
    end

    // Write then read, including same-word byte offset.
    @(negedge clk);
    addr = 32'd127;
    wd   = 32'h0000_000F;
    we   = 1'b1;
    tick();
    we = 1'b0;
    #1 check("wr_rd_127", rd, 32'h0000_000F);
    addr = 32'd124;
    #1 check("wr_rd_124", rd, 32'h0000_000F);
    addr = 32'd0;
    #1 check("wr_rd_0", rd, 32'h0);

    // Combinational read: change addr inside one clock low phase.
    @(negedge clk);
    addr = 32'd0;
    #1 check("comb_rd_before", rd, 32'h0);
    addr = 32'd127;
    #1 check("comb_rd_after", rd, 32'h0000_000F);

    // Write disabled across several edges.
    @(negedge clk);
    addr = 32'd0;
    wd   = 32'h1;
    we   = 1'b0;
    repeat (3) tick();
    check("we_low_hold", rd, 32'h0);

    // Reset priority over a simultaneous write.
    @(negedge clk);
    rst  = 1'b1;
    we   = 1'b1;
    addr = 32'd8;
    wd   = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    we  = 1'b0;
    #1 check("rst_prio_8", rd, 32'h0);
    addr = 32'd124;
    #1 check("rst_clears_127", rd, 32'h0);

    // Write addr 8, read through the DEPTH*4 alias.
    @(negedge clk);
    addr = 32'd8;
    wd   = 32'h1234_5678;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    addr = 32'd8 + 32'(DEPTH * 4);
    #1 check("alias_8", rd, 32'h1234_5678);
    addr = 32'd12;
    #1 check("isolate_12", rd, 32'h0);
    addr = 32'd4;
    #1 check("isolate_4", rd, 32'h0);

    // Read-during-write at addr 16: old word before the edge, new after.
    @(negedge clk);
    addr = 32'd16;
    wd   = 32'hA5A5_0001;
    we   = 1'b1;
    tick();
    @(negedge clk);
    wd = 32'h5A5A_0002;
    we = 1'b1;
    #1 check("rdw_before", rd, 32'hA5A5_0001);
    tick();
    we = 1'b0;
    check("rdw_after", rd, 32'h5A5A_0002);
    addr = 32'd19;
    #1 check("byte_offset_ignored", rd, 32'h5A5A_0002);
    addr = 32'h8000_0010;
    #1 check("upper_bits_ignored", rd, 32'h5A5A_0002);
    addr = 32'd8;
    #1 check("rdw_keeps_8", rd, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem.md
DMEM -- requirements
Module: dmem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, giving the number of 32-bit words stored; it SHALL be a power of two, minimum 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port we, input, 1 bit, the write enable.
REQ-005 The block SHALL have port addr, input, 32 bits, a byte address.
REQ-006 The block SHALL have port wd, input, 32 bits, the write data.
REQ-007 The block SHALL have port rd, output, 32 bits, the read data.
REQ-008 The block SHALL use one clock; reset SHALL be synchronous and active-high, on ports clk and rst.

Function
REQ-009 Storage SHALL be DEPTH words of 32 bits each.
REQ-010 Word index SHALL be addr[log2(DEPTH)+1:2]:
- addr[1:0] ignored (no byte/half access, no misalignment fault).
- addr bits above the index field ignored, so addresses alias modulo DEPTH*4.
REQ-011 Read SHALL be combinational: rd = mem[index] at all times, updating within the same cycle when addr changes, with no clock latency.
REQ-012 Write SHALL occur on rising clk when we=1 and rst=0: mem[index] <= wd, a full 32-bit word.
REQ-013 When we=0, memory contents SHALL be unchanged.
REQ-014 Read-during-write to the same index SHALL show the old word on rd before the write edge and wd after the write edge; there is no write-through bypass.
REQ-015 A write SHALL affect only the addressed word; all other words retain their values.
REQ-016 X/undefined we SHALL be treated as no write in simulation, guarded so memory is not corrupted.

Reset
REQ-017 On a rising clk edge with rst=1, every memory word SHALL be cleared to 32'h0000_0000.
REQ-018 rst SHALL have priority over we; a write presented in a reset cycle is discarded.
REQ-019 After reset, rd SHALL read 0 for every address until written.
REQ-020 Reset SHALL have no asynchronous effect: contents change only at the clock edge while rst is high.
REQ-021 Before the first reset edge, contents are unspecified and benches SHALL NOT check them.

Verification
REQ-022 Reset clear:
- Hold rst=1 for 2 edges, then rst=0, we=0.
- Sweep addr 0, 4, ..., 4*(DEPTH-1): rd SHALL be 0 at each.
REQ-023 Write then read:
- After reset, addr=127, wd=32'h0000_000F, we=1, one edge, then we=0.
- addr=127 SHALL read 0xF; addr=124 SHALL read 0xF (same word); addr=0 SHALL read 0.
REQ-024 Combinational read:
- After REQ-023, switch addr 0 -> 127 mid-cycle with no clock edge.
- rd SHALL change 0 -> 0xF within that cycle.
REQ-025 Write disabled:
- addr=0, wd=1, we=0 across several edges.
- rd at addr 0 SHALL remain 0.
REQ-026 Reset priority and aliasing:
- rst=1 and we=1 with wd=32'hDEAD_BEEF at addr 8 on the same edge: addr 8 SHALL read 0 afterwards.
- Then write 32'h1234_5678 to addr 8 with rst=0: addr 8 + DEPTH*4 SHALL read 32'h1234_5678.
REQ-027 Read-during-write:
- addr=16 holds A; present we=1, wd=B.
- rd SHALL equal A before the edge and B after the edge.
